// File: rtl/cnn_pkg.sv
// Shared MNIST CNN geometry and small helpers used across the datapath.
package cnn_pkg;

  localparam int unsigned IMG_W = 28;
  localparam int unsigned IMG_H = 28;
  localparam int unsigned K     = 5;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned OUT_W = IMG_W - K + 1;
  localparam int unsigned OUT_H = IMG_H - K + 1;

  // Index width for a 0..n-1 counter, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle of conv_window_gen. win_row/win_col exist only with WIN_COORD_EN.
interface conv_window_gen_if #(
  parameter int unsigned K     = cnn_pkg::K,
  parameter int unsigned PIX_W = cnn_pkg::PIX_W,
  parameter int unsigned ROW_W = cnn_pkg::idx_w(cnn_pkg::OUT_H),
  parameter int unsigned COL_W = cnn_pkg::idx_w(cnn_pkg::OUT_W)
);

  logic                   in_valid;
  logic [PIX_W-1:0]       pixel;
  logic                   win_valid;
  logic [K*K*PIX_W-1:0]   win_data;
  logic                   frame_done;
`ifdef WIN_COORD_EN
  logic [ROW_W-1:0]       win_row;
  logic [COL_W-1:0]       win_col;
`endif

  modport master (
    output in_valid,
    output pixel,
    input  win_valid,
    input  win_data,
`ifdef WIN_COORD_EN
    input  win_row,
    input  win_col,
`endif
    input  frame_done
  );

  modport slave (
    input  in_valid,
    input  pixel,
    output win_valid,
    output win_data,
`ifdef WIN_COORD_EN
    output win_row,
    output win_col,
`endif
    output frame_done
  );

endinterface

// File: rtl/line_delay.sv
// Enabled shift delay of Depth samples; one image row of history in the window generator.
module line_delay #(
  parameter int unsigned Depth = cnn_pkg::IMG_W,
  parameter int unsigned Width = cnn_pkg::PIX_W
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] mem_q [Depth];

  // Contents are don't-care after reset; the consumer's row gating hides them.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[0] <= d_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign q_o = mem_q[Depth-1];

endmodule

// File: rtl/conv_window_gen.sv
// K x K sliding-window generator over a raster pixel stream, one window per accepted pixel
// once row and col reach K-1. Define WIN_COORD_EN to add the win_row/win_col outputs.
module conv_window_gen #(
  parameter int unsigned IMG_W = cnn_pkg::IMG_W,
  parameter int unsigned IMG_H = cnn_pkg::IMG_H,
  parameter int unsigned K     = cnn_pkg::K,
  parameter int unsigned PIX_W = cnn_pkg::PIX_W
) (
  input  logic               clk,
  input  logic               rst,
  conv_window_gen_if.slave   win_if
);
  import cnn_pkg::*;

  localparam int unsigned ColW    = idx_w(IMG_W);
  localparam int unsigned RowW    = idx_w(IMG_H);
  localparam int unsigned OutRowW = idx_w(IMG_H - K + 1);
  localparam int unsigned OutColW = idx_w(IMG_W - K + 1);
  localparam int unsigned WinW    = K * K * PIX_W;

  localparam logic [ColW-1:0] ColLast  = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] ColFirst = ColW'(K - 1);
  localparam logic [RowW-1:0] RowFirst = RowW'(K - 1);

  logic             accept;
  logic             complete;
  logic             last_win;
  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [WinW-1:0]  win_data_q;
  logic             win_valid_q;
  logic             frame_done_q;
  logic [PIX_W-1:0] ld_in [K-1];
  logic [PIX_W-1:0] tap   [K-1];

  // A pixel offered while reset is low is dropped.
  assign accept = win_if.in_valid & rst;

  // tap[i] is the pixel i+1 rows above the incoming one.
  for (genvar i = 0; i < K - 1; i++) begin : g_line
    if (i == 0) begin : g_head
      assign ld_in[i] = win_if.pixel;
    end else begin : g_chain
      assign ld_in[i] = tap[i-1];
    end
    line_delay #(
      .Depth (IMG_W),
      .Width (PIX_W)
    ) u_line_delay (
      .clk_i (clk),
      .en_i  (accept),
      .d_i   (ld_in[i]),
      .q_o   (tap[i])
    );
  end

  always_comb begin
    win_d = win_q;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K - 1; c++) begin
        win_d[(r*K+c)*PIX_W +: PIX_W] = win_q[(r*K+c+1)*PIX_W +: PIX_W];
      end
    end
    for (int unsigned r = 0; r < K - 1; r++) begin
      win_d[(r*K+K-1)*PIX_W +: PIX_W] = tap[K-2-r];
    end
    win_d[(K*K-1)*PIX_W +: PIX_W] = win_if.pixel;
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign complete = accept && (row_q >= RowFirst) && (col_q >= ColFirst);
  assign last_win = complete && (row_q == RowLast) && (col_q == ColLast);

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_data_q   <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= complete;
      frame_done_q <= last_win;
      if (complete) begin
        win_data_q <= win_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      win_q <= win_d;
    end
  end

  assign win_if.win_valid  = win_valid_q;
  assign win_if.frame_done = frame_done_q;
  assign win_if.win_data   = win_data_q;

`ifdef WIN_COORD_EN
  logic [RowW-1:0]    out_row;
  logic [ColW-1:0]    out_col;
  logic [OutRowW-1:0] win_row_q;
  logic [OutColW-1:0] win_col_q;

  assign out_row = row_q - RowFirst;
  assign out_col = col_q - ColFirst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else if (complete) begin
      win_row_q <= OutRowW'(out_row);
      win_col_q <= OutColW'(out_col);
    end
  end

  assign win_if.win_row = win_row_q;
  assign win_if.win_col = win_col_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: ramp images, gapped input, back-to-back frames, mid-frame reset.
module tb_conv_window_gen;
  import cnn_pkg::*;

  typedef struct {
    logic [7:0] off;
    logic [7:0] e0f;
    logic [7:0] e24f;
    logic [7:0] e0l;
    logic [7:0] e24l;
  } img_t;

  localparam int unsigned WinW   = K * K * PIX_W;
  localparam int unsigned NWin   = OUT_W * OUT_H;
  localparam int unsigned NPix   = IMG_W * IMG_H;
  localparam int unsigned TopLsb = (K * K - 1) * PIX_W;

  logic clk = 1'b0;
  logic rst;

  conv_window_gen_if bus ();

  conv_window_gen dut (
    .clk    (clk),
    .rst    (rst),
    .win_if (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  img_t        img_q[$];
  bit          mon_en   = 1'b0;
  bit          iv_prev  = 1'b0;
  bit          rst_prev = 1'b1;
  int unsigned acc      = 0;
  int unsigned wcnt     = 0;
  int unsigned frames   = 0;
  int unsigned wr, wc;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WinW-1:0] exp_win(input logic [7:0] off, input int unsigned r0,
                                               input int unsigned c0);
    logic [WinW-1:0] w;
    logic [7:0]      v;
    w = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        v = 8'((r0 + r) * IMG_W + c0 + c) + off;
        w[(r*K+c)*PIX_W +: PIX_W] = v;
      end
    end
    return w;
  endfunction

  // Sampled mid-cycle: outputs reflect the posedge just passed, iv_prev/rst_prev its inputs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_prev) begin
        acc  = 0;
        wcnt = 0;
        check("rst_win_valid", 256'(bus.win_valid), 256'(0));
        check("rst_frame_done", 256'(bus.frame_done), 256'(0));
        check("rst_win_data", 256'(bus.win_data), 256'(0));
      end else begin
        if (iv_prev) acc++;
        else check("idle_win_valid", 256'(bus.win_valid), 256'(0));
        if (!bus.win_valid) begin
          check("fd_without_wv", 256'(bus.frame_done), 256'(0));
        end else if (img_q.size() == 0) begin
          check("unexpected_window", 256'(img_q.size()), 256'(1));
        end else begin
          wr = wcnt / OUT_W;
          wc = wcnt % OUT_W;
          check("win_data", 256'(bus.win_data), 256'(exp_win(img_q[0].off, wr, wc)));
          check("frame_done", 256'(bus.frame_done), 256'(wcnt == NWin - 1));
`ifdef WIN_COORD_EN
          check("win_row", 256'(bus.win_row), 256'(wr));
          check("win_col", 256'(bus.win_col), 256'(wc));
`endif
          if (wcnt == 0) begin
            check("first_latency", 256'(acc), 256'(117));
            check("first_e0", 256'(bus.win_data[PIX_W-1:0]), 256'(img_q[0].e0f));
            check("first_e24", 256'(bus.win_data[TopLsb +: PIX_W]), 256'(img_q[0].e24f));
          end
          if (wcnt == NWin - 1) begin
            check("last_e0", 256'(bus.win_data[PIX_W-1:0]), 256'(img_q[0].e0l));
            check("last_e24", 256'(bus.win_data[TopLsb +: PIX_W]), 256'(img_q[0].e24l));
            check("frame_pixels", 256'(acc), 256'(NPix));
            acc  = 0;
            wcnt = 0;
            frames++;
            void'(img_q.pop_front());
          end else begin
            wcnt++;
          end
        end
      end
      iv_prev  = bus.in_valid;
      rst_prev = rst;
    end
  end

  task automatic image(input img_t e, input bit toggle, input int unsigned npix);
    img_q.push_back(e);
    for (int unsigned i = 0; i < npix; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.pixel    = 8'(i) + e.off;
      if (toggle) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // The pixel offered during reset must be dropped.
  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.pixel    = 8'hAA;
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    img_q.delete();
  endtask

  img_t ramp, ramp40;

  initial begin
    ramp   = '{off: 8'h00, e0f: 8'h00, e24f: 8'h74, e0l: 8'h9B, e24l: 8'h0F};
    ramp40 = '{off: 8'h40, e0f: 8'h40, e24f: 8'hB4, e0l: 8'hDB, e24l: 8'h4F};
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.pixel    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_win_valid", 256'(bus.win_valid), 256'(0));
    check("reset_frame_done", 256'(bus.frame_done), 256'(0));
    check("reset_win_data", 256'(bus.win_data), 256'(0));
`ifdef WIN_COORD_EN
    check("reset_win_row", 256'(bus.win_row), 256'(0));
    check("reset_win_col", 256'(bus.win_col), 256'(0));
`endif
    @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    image(ramp, 1'b0, NPix);
    idle(3);
    image(ramp, 1'b1, NPix);
    idle(3);
    image(ramp, 1'b0, NPix);
    image(ramp40, 1'b0, NPix);
    idle(3);
    image(ramp, 1'b0, 300);
    reset_pulse();
    image(ramp, 1'b0, NPix);
    idle(3);

    for (int i = 0; i < 20 && img_q.size() != 0; i++) @(posedge clk);
    check("drain", 256'(img_q.size()), 256'(0));
    check("frames", 256'(frames), 256'(5));
    check("windows_left", 256'(wcnt), 256'(0));

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Front stage of the MNIST CNN datapath. It accepts the raw 8-bit pixel stream, one pixel per cycle in raster order and 784 pixels per 28x28 image. It emits every K x K neighbourhood (5x5 by default) as one flat window word for the first convolution layer. Storage is K-1 row line buffers plus a K x K window register. There is no back-pressure: the consumer takes every window in the cycle it is valid.

## Interface
Parameters:
- IMG_W, default 28: image width in pixels.
- IMG_H, default 28: image height in pixels.
- K, default 5: window size (K x K).
- PIX_W, default 8: pixel width in bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low.
- in_valid  in  1  pixel qualifier.
- pixel  in  PIX_W  unsigned pixel.
- win_valid  out  1  window qualifier.
- win_data  out  K*K*PIX_W  window contents.
- frame_done  out  1  one-cycle pulse, coincident with the last window of an image.
- win_row  out  $clog2(IMG_H-K+1)  output row, 0..IMG_H-K. Present only with WIN_COORD_EN.
- win_col  out  $clog2(IMG_W-K+1)  output column, 0..IMG_W-K. Present only with WIN_COORD_EN.

## Operation
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) track the position of the incoming pixel.
  - Both advance only on in_valid.
  - col wraps to 0 and increments row. At (IMG_H-1, IMG_W-1), both wrap to 0.
- Line buffers: K-1 cascaded row delays, each IMG_W deep, shift only on in_valid.
- Window register shifts left by one column on in_valid. The new right column is loaded as follows:
  - bottom element = pixel;
  - other elements = line buffer taps, oldest row at the top.
- A window is complete when the accepted pixel has row >= K-1 and col >= K-1.
  - Gating by row and col guarantees that no emitted window spans two images or a row wrap.
  - Stale line-buffer data from the previous image is never exposed.
- Element ordering: win_data[(r*K+c)*PIX_W +: PIX_W] = pixel(row-(K-1)+r, col-(K-1)+c).
  - Element 0, the top-left pixel, sits at the LSBs.
  - Element K*K-1, the newest pixel, sits at the MSBs.
- Each image produces exactly (IMG_H-K+1)*(IMG_W-K+1) windows: 576 by default.
- in_valid low: no state changes. win_valid = 0 and frame_done = 0 in the following cycle. win_data holds its last value.
- Back-to-back images need no idle cycle: pixel 0 of the next image may follow pixel 783 directly.

## Timing
- Latency is 1 cycle: win_valid, win_data, frame_done and coordinates are registered on the edge that accepts the completing pixel.
- win_valid is high for one cycle per completed window. Consecutive valid inputs inside the valid region give consecutive valid windows.
- frame_done is asserted together with win_valid for window (IMG_H-K, IMG_W-K).
- Reset values: win_valid = 0, frame_done = 0, win_data = 0, win_row = 0, win_col = 0, row = 0, col = 0.
  - Line buffer contents need no reset.
- Reset while a frame is in progress: counters and outputs clear on that edge. The next accepted pixel is treated as pixel (0,0).
- rst low has priority over in_valid in the same cycle; the pixel is dropped.

## Configuration
- Macro WIN_COORD_EN.
  - Defined: win_row/win_col ports exist and carry the output coordinate of the window, registered with win_valid. The pair holds when win_valid is low.
  - Undefined: the ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package cnn_pkg holds IMG_W, IMG_H, K, PIX_W and derived OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1. The rest of the CNN reuses these.
- Sub-module line_delay: one IMG_W-deep, PIX_W-wide shift delay with an enable. It is instantiated K-1 times.
- Top level holds the counters, window register and output registers.

## Test plan
All scenarios use default parameters unless stated.
1. Ramp image, pixel = (r*28+c) & 0xFF, in_valid held high -> first win_valid one cycle after pixel index 116, with element 0 = 0x00 and element 24 = 0x74. Exactly 576 windows are produced.
2. Same image, last window -> frame_done pulses once, with element 0 = 0x9B and element 24 = 0x0F. Counters return to (0,0).
3. Same image with in_valid toggled every other cycle -> same 576 windows in the same order. win_valid is never high in the cycle after an idle input.
4. Two back-to-back images, second is the ramp + 0x40 -> 576 windows each. The first window of image 2 appears one cycle after its pixel 116 and has element 0 = 0x40. No window mixes data from the two images.
5. rst low for one cycle after 300 pixels, then a full ramp image -> win_valid = 0 and frame_done = 0 from that edge. The following image behaves exactly as scenario 1.
6. With WIN_COORD_EN, ramp image -> the (win_row, win_col) sequence runs (0,0), (0,1) ... (23,23). (0,0) carries element 24 = 0x74, and frame_done is asserted with (23,23).
